// File: rtl/axis_pkt_gen_v1_0_if.sv
// rtl/axis_pkt_gen_v1_0_if.sv - AXI4-Stream bundle for the packet generator
interface axis_pkt_gen_v1_0_if #(
  parameter int DATA_W = 32,
  parameter int USER_W = 1
);
  localparam int STRB_W = DATA_W / 8;

  logic [DATA_W-1:0] tdata;
  logic [STRB_W-1:0] tstrb;
  logic              tvalid;
  logic              tready;
  logic              tlast;
  logic [USER_W-1:0] tuser;

  modport master (output tdata, output tstrb, output tvalid, output tlast, output tuser,
                  input tready);
  modport slave  (input tdata, input tstrb, input tvalid, input tlast, input tuser,
                  output tready);
endinterface

// File: rtl/axis_pkt_gen_v1_0.sv
// rtl/axis_pkt_gen_v1_0.sv - AXI4-Stream packet traffic generator
module axis_pkt_gen_v1_0 #(
  parameter int C_AXIS_TDATA_WIDTH = 32,
  parameter int TUSER_WIDTH        = 1,
  parameter int LEN_WIDTH          = 16,
  parameter int CNT_WIDTH          = 16,
  parameter int GAP_WIDTH          = 8
) (
  input  logic                          m00_axis_aclk,
  input  logic                          m00_axis_areset,
  input  logic                          start,
  input  logic [LEN_WIDTH-1:0]          cfg_byte_len,
  input  logic [CNT_WIDTH-1:0]          cfg_pkt_count,
  input  logic [GAP_WIDTH-1:0]          cfg_gap,
  input  logic [C_AXIS_TDATA_WIDTH-1:0] cfg_seed,
  axis_pkt_gen_v1_0_if.master           m00_axis,
  output logic                          busy,
  output logic                          done,
  output logic [CNT_WIDTH-1:0]          pkts_sent
);
  localparam int BYTES = C_AXIS_TDATA_WIDTH / 8;
  localparam int LOG2B = $clog2(BYTES);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_DONE} state_t;

  state_t                        state_q, state_d;
  logic                          tvalid_q, tvalid_d;
  logic [C_AXIS_TDATA_WIDTH-1:0] tdata_q, tdata_d;
  logic [BYTES-1:0]              tstrb_q, tstrb_d;
  logic                          tlast_q, tlast_d;
  logic [TUSER_WIDTH-1:0]        tuser_q, tuser_d;
  logic                          busy_q, busy_d;
  logic                          done_q, done_d;
  logic [CNT_WIDTH-1:0]          pkts_q, pkts_d;
  logic [C_AXIS_TDATA_WIDTH-1:0] word_cnt_q, word_cnt_d;
  logic [LEN_WIDTH-1:0]          beat_cnt_q, beat_cnt_d;
  logic [GAP_WIDTH-1:0]          gap_cnt_q, gap_cnt_d;
  logic [LEN_WIDTH-1:0]          beats_q, beats_d;
  logic [BYTES-1:0]              last_strb_q, last_strb_d;
  logic [CNT_WIDTH-1:0]          count_q, count_d;
  logic [GAP_WIDTH-1:0]          gap_q, gap_d;
  logic [C_AXIS_TDATA_WIDTH-1:0] seed_q, seed_d;

  logic [LEN_WIDTH:0]   len_round;
  logic [LEN_WIDTH-1:0] acc_beats;
  logic [LEN_WIDTH-1:0] acc_rem;
  logic [BYTES-1:0]     acc_strb;
  logic                 present;
  logic                 beat_is_last;

  // Packet geometry from the live config, captured only when a start is accepted
  always_comb begin
    len_round = {1'b0, cfg_byte_len} + (LEN_WIDTH+1)'(BYTES - 1);
    acc_beats = LEN_WIDTH'(len_round >> LOG2B);
    acc_rem   = cfg_byte_len & LEN_WIDTH'(BYTES - 1);
    acc_strb  = '0;
    for (int i = 0; i < BYTES; i++) begin
      acc_strb[i] = (acc_rem == '0) || (i < int'(acc_rem));
    end
  end

  // Next-state logic; "present" loads the beat addressed by word_cnt_d/beat_cnt_d
  always_comb begin
    state_d      = state_q;
    tvalid_d     = tvalid_q;
    tdata_d      = tdata_q;
    tstrb_d      = tstrb_q;
    tlast_d      = tlast_q;
    tuser_d      = tuser_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    pkts_d       = pkts_q;
    word_cnt_d   = word_cnt_q;
    beat_cnt_d   = beat_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    beats_d      = beats_q;
    last_strb_d  = last_strb_q;
    count_d      = count_q;
    gap_d        = gap_q;
    seed_d       = seed_q;
    present      = 1'b0;
    beat_is_last = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && (cfg_byte_len != '0) && (cfg_pkt_count != '0)) begin
          beats_d     = acc_beats;
          last_strb_d = acc_strb;
          count_d     = cfg_pkt_count;
          gap_d       = cfg_gap;
          seed_d      = cfg_seed;
          pkts_d      = '0;
          word_cnt_d  = '0;
          beat_cnt_d  = '0;
          busy_d      = 1'b1;
          state_d     = S_SEND;
        end
      end
      S_SEND: begin
        if (!tvalid_q) begin
          present = 1'b1;
        end else if (m00_axis.tready) begin
          word_cnt_d = word_cnt_q + 1'b1;
          if (tlast_q) begin
            pkts_d     = pkts_q + 1'b1;
            beat_cnt_d = '0;
            if (pkts_d == count_q) begin
              tvalid_d = 1'b0;
              tlast_d  = 1'b0;
              tuser_d  = '0;
              busy_d   = 1'b0;
              done_d   = 1'b1;
              state_d  = S_DONE;
            end else if (gap_q == '0) begin
              present = 1'b1;
            end else begin
              tvalid_d  = 1'b0;
              gap_cnt_d = gap_q;
              state_d   = S_GAP;
            end
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
            present    = 1'b1;
          end
        end
      end
      S_GAP: begin
        // Loading the beat on the final gap cycle keeps the idle window exactly gap_q long
        if (gap_cnt_q <= GAP_WIDTH'(1)) begin
          present = 1'b1;
          state_d = S_SEND;
        end else begin
          gap_cnt_d = gap_cnt_q - 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (present) begin
      beat_is_last = (beat_cnt_d == (beats_q - LEN_WIDTH'(1)));
      tvalid_d     = 1'b1;
      tdata_d      = seed_q + word_cnt_d;
      tlast_d      = beat_is_last;
      tstrb_d      = beat_is_last ? last_strb_q : '1;
      tuser_d      = '0;
      tuser_d[0]   = (beat_cnt_d == '0);
    end
  end

  // State and output registers
  always_ff @(posedge m00_axis_aclk) begin
    if (m00_axis_areset) begin
      state_q     <= S_IDLE;
      tvalid_q    <= 1'b0;
      tdata_q     <= '0;
      tstrb_q     <= '0;
      tlast_q     <= 1'b0;
      tuser_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pkts_q      <= '0;
      word_cnt_q  <= '0;
      beat_cnt_q  <= '0;
      gap_cnt_q   <= '0;
      beats_q     <= '0;
      last_strb_q <= '0;
      count_q     <= '0;
      gap_q       <= '0;
      seed_q      <= '0;
    end else begin
      state_q     <= state_d;
      tvalid_q    <= tvalid_d;
      tdata_q     <= tdata_d;
      tstrb_q     <= tstrb_d;
      tlast_q     <= tlast_d;
      tuser_q     <= tuser_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pkts_q      <= pkts_d;
      word_cnt_q  <= word_cnt_d;
      beat_cnt_q  <= beat_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      beats_q     <= beats_d;
      last_strb_q <= last_strb_d;
      count_q     <= count_d;
      gap_q       <= gap_d;
      seed_q      <= seed_d;
    end
  end

  assign m00_axis.tvalid = tvalid_q;
  assign m00_axis.tdata  = tdata_q;
  assign m00_axis.tstrb  = tstrb_q;
  assign m00_axis.tlast  = tlast_q;
  assign m00_axis.tuser  = tuser_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign pkts_sent       = pkts_q;
endmodule

// File: tb/tb_axis_pkt_gen_v1_0.sv
// tb/tb_axis_pkt_gen_v1_0.sv - directed self-checking bench for axis_pkt_gen_v1_0
module tb_axis_pkt_gen_v1_0;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] cfg_byte_len = '0;
  logic [15:0] cfg_pkt_count = '0;
  logic [7:0]  cfg_gap = '0;
  logic [31:0] cfg_seed = '0;
  logic        busy;
  logic        done;
  logic [15:0] pkts_sent;

  axis_pkt_gen_v1_0_if #(.DATA_W(32), .USER_W(1)) axis ();

  axis_pkt_gen_v1_0 dut (
    .m00_axis_aclk   (clk),
    .m00_axis_areset (rst),
    .start           (start),
    .cfg_byte_len    (cfg_byte_len),
    .cfg_pkt_count   (cfg_pkt_count),
    .cfg_gap         (cfg_gap),
    .cfg_seed        (cfg_seed),
    .m00_axis        (axis),
    .busy            (busy),
    .done            (done),
    .pkts_sent       (pkts_sent)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  int          cyc = 0;
  logic [31:0] hs_data[$];
  logic [3:0]  hs_strb[$];
  bit          hs_user[$];
  bit          hs_last[$];
  int          hs_cyc[$];
  logic [15:0] pk_q[$];
  bit          vhist[$];
  bit          rec = 1'b0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  logic        done_busy = 1'b0;
  logic [15:0] done_pkts = '0;
  logic [15:0] pk_prev = '0;
  logic        stall = 1'b0;
  logic [38:0] snap = '0;
  int          go_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Observe the stream half a cycle away from the active edge
  always @(negedge clk) begin
    if (rst) begin
      stall <= 1'b0;
    end else begin
      if (stall)
        check_eq("hold_stable", {axis.tvalid, axis.tdata, axis.tstrb, axis.tlast, axis.tuser}, snap);
      stall <= axis.tvalid && !axis.tready;
      snap  <= {axis.tvalid, axis.tdata, axis.tstrb, axis.tlast, axis.tuser};
      if (axis.tvalid && axis.tready) begin
        hs_data.push_back(axis.tdata);
        hs_strb.push_back(axis.tstrb);
        hs_user.push_back(axis.tuser[0]);
        hs_last.push_back(axis.tlast);
        hs_cyc.push_back(cyc);
      end
      if (done) begin
        done_cnt  <= done_cnt + 1;
        done_cyc  <= cyc;
        done_busy <= busy;
        done_pkts <= pkts_sent;
      end
      if (pkts_sent != pk_prev && pkts_sent != '0) pk_q.push_back(pkts_sent);
      pk_prev <= pkts_sent;
      if (rec) vhist.push_back(axis.tvalid);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clr();
    hs_data.delete(); hs_strb.delete(); hs_user.delete(); hs_last.delete();
    hs_cyc.delete(); pk_q.delete(); vhist.delete();
  endtask

  task automatic go(input logic [15:0] len, input logic [15:0] cnt, input logic [7:0] gap,
                    input logic [31:0] seed);
    cfg_byte_len = len; cfg_pkt_count = cnt; cfg_gap = gap; cfg_seed = seed;
    start = 1'b1;
    tick();
    go_cyc = cyc;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int d0;
    int n;
    d0 = done_cnt;
    n = 0;
    while (done_cnt == d0 && n < budget) begin
      tick();
      n++;
    end
    check_eq(tag, (done_cnt != d0), 1);
  endtask

  function automatic logic [6:0] vpat7();
    int f;
    logic [6:0] v;
    f = 0;
    v = '0;
    while (f < vhist.size() && !vhist[f]) f++;
    for (int k = 0; k < 7; k++) v = {v[5:0], (f + k < vhist.size()) ? vhist[f + k] : 1'b0};
    return v;
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    logic [31:0] ed[3];
    logic [3:0]  es[3];
    bit          eu[3];
    bit          bp[7];
    int          n;
    int          d0;

    // Reset with start and tready held high
    axis.tready = 1'b1;
    start = 1'b1;
    cfg_byte_len = 16'd8; cfg_pkt_count = 16'd1; cfg_seed = 32'h5;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("rst_outputs", {axis.tvalid, busy, done, axis.tdata, axis.tstrb,
                               axis.tlast, axis.tuser, pkts_sent}, 0);
    end
    rst = 1'b0;
    start = 1'b0;
    tick();
    tick();
    check_eq("post_rst_busy", busy, 0);
    check_eq("post_rst_valid", axis.tvalid, 0);

    // Basic 10-byte packet
    clr();
    go(16'd10, 16'd1, 8'd0, 32'h100);
    wait_done("basic_done", 20);
    ed = '{32'h100, 32'h101, 32'h102};
    es = '{4'hF, 4'hF, 4'h3};
    eu = '{1'b1, 1'b0, 1'b0};
    check_eq("basic_beats", hs_data.size(), 3);
    for (int i = 0; i < 3; i++) begin
      check_eq("basic_data", hs_data[i], ed[i]);
      check_eq("basic_strb", hs_strb[i], es[i]);
      check_eq("basic_user", hs_user[i], eu[i]);
      check_eq("basic_last", hs_last[i], (i == 2));
    end
    check_eq("basic_first_lat", hs_cyc[0] - go_cyc, 1);
    check_eq("basic_done_lat", done_cyc - hs_cyc[2], 1);
    check_eq("basic_done_busy", done_busy, 0);
    check_eq("basic_done_pkts", done_pkts, 1);
    check_eq("basic_pkts_hold", pkts_sent, 1);

    // Backpressure on a 16-byte packet
    clr();
    bp = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    axis.tready = 1'b0;
    go(16'd16, 16'd1, 8'd0, 32'h55);
    n = 0;
    while (!axis.tvalid && n < 10) begin
      tick();
      n++;
    end
    check_eq("bp_valid_up", axis.tvalid, 1);
    for (int i = 0; i < 7; i++) begin
      axis.tready = bp[i];
      tick();
    end
    axis.tready = 1'b1;
    wait_done("bp_done", 10);
    check_eq("bp_beats", hs_data.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check_eq("bp_data", hs_data[i], 32'h55 + i);
      check_eq("bp_strb", hs_strb[i], 4'hF);
      check_eq("bp_last", hs_last[i], (i == 3));
    end

    // Three single-beat packets separated by two idle cycles
    clr();
    rec = 1'b1;
    go(16'd4, 16'd3, 8'd2, 32'h200);
    wait_done("gap2_done", 30);
    rec = 1'b0;
    check_eq("gap2_vpat", vpat7(), 7'b1001001);
    check_eq("gap2_beats", hs_data.size(), 3);
    for (int i = 0; i < 3; i++) begin
      check_eq("gap2_data", hs_data[i], 32'h200 + i);
      check_eq("gap2_user_last", {hs_user[i], hs_last[i]}, 2'b11);
      check_eq("gap2_pkts_step", pk_q[i], i + 1);
    end
    check_eq("gap2_pkts_steps", pk_q.size(), 3);

    // Same with no gap: back-to-back beats
    clr();
    rec = 1'b1;
    go(16'd4, 16'd3, 8'd0, 32'h210);
    wait_done("gap0_done", 30);
    rec = 1'b0;
    check_eq("gap0_vpat", vpat7(), 7'b1110000);
    check_eq("gap0_last_data", hs_data[2], 32'h212);

    // Starts with zero length or zero count are ignored
    go(16'd0, 16'd1, 8'd0, 32'h1);
    tick();
    check_eq("len0_busy", busy, 0);
    check_eq("len0_valid", axis.tvalid, 0);
    go(16'd4, 16'd0, 8'd0, 32'h1);
    tick();
    check_eq("cnt0_busy", busy, 0);

    // A start pulsed mid-run has no effect
    clr();
    go(16'd12, 16'd2, 8'd1, 32'h20);
    tick();
    tick();
    cfg_seed = 32'h999; cfg_byte_len = 16'd4; cfg_pkt_count = 16'd7;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("midstart_done", 30);
    check_eq("midstart_beats", hs_data.size(), 6);
    for (int i = 0; i < 6; i++) check_eq("midstart_data", hs_data[i], 32'h20 + i);
    check_eq("midstart_pkts", done_pkts, 2);

    // Data wraps modulo 2^32
    clr();
    go(16'd8, 16'd1, 8'd0, 32'hFFFF_FFFF);
    wait_done("wrap_done", 20);
    check_eq("wrap_beats", hs_data.size(), 2);
    check_eq("wrap_d0", hs_data[0], 32'hFFFF_FFFF);
    check_eq("wrap_d1", hs_data[1], 32'h0);

    // Reset mid-packet abandons the packet without a done pulse
    clr();
    go(16'd40, 16'd1, 8'd0, 32'h300);
    n = 0;
    while (hs_data.size() < 3 && n < 30) begin
      tick();
      n++;
    end
    check_eq("rmid_three", hs_data.size(), 3);
    d0 = done_cnt;
    rst = 1'b1;
    tick();
    check_eq("rmid_valid", axis.tvalid, 0);
    check_eq("rmid_busy", busy, 0);
    rst = 1'b0;
    tick();
    tick();
    check_eq("rmid_no_done", done_cnt - d0, 0);
    check_eq("rmid_beats", hs_data.size(), 3);
    clr();
    go(16'd4, 16'd1, 8'd0, 32'h400);
    wait_done("rmid_restart_done", 20);
    check_eq("rmid_restart_beats", hs_data.size(), 1);
    check_eq("rmid_restart_data", hs_data[0], 32'h400);
    check_eq("rmid_restart_user", hs_user[0], 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
